// File: rtl/strobe_exec_unit_pkg.sv
// Shared definitions for the strobe execution unit: top FSM state encoding,
// nibble-handshake state encoding, bus command nibbles and the default
// per-edge ack timeout.
package strobe_exec_unit_pkg;

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    CMD  = 4'd1,
    A_HI = 4'd2,
    A_LO = 4'd3,
    D_HI = 4'd4,
    D_LO = 4'd5,
    R_HI = 4'd6,
    R_LO = 4'd7,
    DONE = 4'd8
  } state_t;

  typedef enum logic [1:0] {
    HS_IDLE = 2'd0,
    HS_PRE  = 2'd1,  // ack still high from before: wait for it to drop
    HS_REQ  = 2'd2,  // req high, waiting for ack rise
    HS_REL  = 2'd3   // req low, waiting for ack fall
  } hs_state_t;

  localparam logic [3:0] CMD_WR = 4'b1000;
  localparam logic [3:0] CMD_RD = 4'b0100;

  localparam int unsigned TIMEOUT_DEF = 15;

endpackage

// File: rtl/strobe_exec_unit_if.sv
// Off-chip memory nibble bus: 4-bit data each way plus 4-phase req/ack.
//   bus_o    : nibble driven toward memory
//   bus_oe_o : bus_o is valid/driven
//   bus_i    : nibble returned by memory
//   req_o    : handshake request
//   ack_i    : handshake acknowledge
// master = execution unit side, slave = memory/responder side.
interface strobe_exec_unit_if;
  logic [3:0] bus_o;
  logic       bus_oe_o;
  logic [3:0] bus_i;
  logic       req_o;
  logic       ack_i;

  modport master (output bus_o, bus_oe_o, req_o, input bus_i, ack_i);
  modport slave  (input bus_o, bus_oe_o, req_o, output bus_i, ack_i);
endinterface

// File: rtl/strobe_exec_unit_nibble_handshake.sv
// One 4-phase nibble transfer with a per-edge timeout counter.
//   start   : begin a transfer (captures nib_out/oe)
//   nib_out : nibble to drive
//   oe      : drive enable for this nibble (0 on read phases)
//   done    : 1 in the cycle ack is seen low after the rise (phase complete)
//   timeout : 1 in the cycle the current ack-edge wait expires
//   nib_in  : bus_i captured when ack was seen high
//   mem     : nibble bus (master side)
module nibble_handshake
  import strobe_exec_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [3:0]         nib_out,
  input  logic               oe,
  output logic               done,
  output logic               timeout,
  output logic [3:0]         nib_in,
  strobe_exec_unit_if.master mem
);

  hs_state_t  hs;
  logic [3:0] cnt;
  logic [3:0] nib_q;
  logic       oe_q;
  logic       edge_seen;

  always_comb begin
    edge_seen = 1'b0;
    case (hs)
      HS_PRE:  edge_seen = !mem.ack_i;
      HS_REQ:  edge_seen = mem.ack_i;
      HS_REL:  edge_seen = !mem.ack_i;
      default: edge_seen = 1'b0;
    endcase
    done    = (hs == HS_REL) && !mem.ack_i;
    timeout = (hs != HS_IDLE) && !edge_seen && (cnt == 4'(TIMEOUT - 1));
  end

  assign mem.req_o    = (hs == HS_REQ);
  assign mem.bus_o    = nib_q;
  assign mem.bus_oe_o = oe_q;

  // The pre-wait for a stale high ack shares its count with the following
  // rise wait; the count restarts only when waiting for the ack fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs     <= HS_IDLE;
      cnt    <= '0;
      nib_q  <= '0;
      oe_q   <= 1'b0;
      nib_in <= '0;
    end else if (start) begin
      hs    <= mem.ack_i ? HS_PRE : HS_REQ;
      cnt   <= '0;
      nib_q <= nib_out;
      oe_q  <= oe;
    end else if (timeout || done) begin
      hs    <= HS_IDLE;
      cnt   <= '0;
      nib_q <= '0;
      oe_q  <= 1'b0;
    end else begin
      case (hs)
        HS_PRE: begin
          if (!mem.ack_i) hs <= HS_REQ;
          cnt <= cnt + 4'd1;
        end
        HS_REQ: begin
          if (mem.ack_i) begin
            hs     <= HS_REL;
            cnt    <= '0;
            nib_in <= mem.bus_i;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        HS_REL:  cnt <= cnt + 4'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/strobe_exec_unit.sv
// Executes one-hot control strobes from the mov/branch decode stage: branch,
// memory write, memory read and output-select toggle. Owns the program
// counter and output-pin select, and sequences memory ops over the nibble
// bus while stalling the core.
//   clk, rst_n      : clock, async active-low reset
//   instr_valid_i   : strobes valid this cycle
//   bcf_i           : pc += r3_i
//   mem_write_i     : write data_i to address r3_i
//   mem_read_i      : read address r3_i into rd_data_o
//   toggle_out_i    : flip out_sel_o
//   r3_i, data_i    : branch offset / address, write data
//   pc_o, stall_o   : program counter, memory op in flight
//   rd_data_o       : last read data, rd_valid_o pulses on update
//   err_o           : pulses on bus timeout abort
//   out_sel_o, pin_o: pin select and pin value
//   mem             : nibble bus (master side)
module strobe_exec_unit
  import strobe_exec_unit_pkg::*;
#(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid_i,
  input  logic               bcf_i,
  input  logic               mem_write_i,
  input  logic               mem_read_i,
  input  logic               toggle_out_i,
  input  logic [DATA_W-1:0]  r3_i,
  input  logic [DATA_W-1:0]  data_i,
  output logic [PC_W-1:0]    pc_o,
  output logic               stall_o,
  output logic [DATA_W-1:0]  rd_data_o,
  output logic               rd_valid_o,
  output logic               err_o,
  output logic               out_sel_o,
  output logic [PC_W-1:0]    pin_o,
  strobe_exec_unit_if.master mem
);

  state_t              state, state_nx;
  logic                accept;
  logic                hs_start, hs_oe, hs_done, hs_timeout;
  logic [3:0]          hs_nib, hs_nib_in;
  logic [DATA_W-1:0]   addr_q, wdata_q;
  logic                op_rd_q;
  logic [3:0]          rd_hi_q;

  // DONE keeps ignoring strobes: the core is still presenting the held
  // memory instruction in that cycle, so only IDLE may accept.
  assign accept  = instr_valid_i && (state == IDLE);
  assign stall_o = (state != IDLE) && (state != DONE);
  assign pin_o   = out_sel_o ? pc_o : PC_W'(r3_i);

  nibble_handshake #(.TIMEOUT(TIMEOUT)) u_hs (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (hs_start),
    .nib_out (hs_nib),
    .oe      (hs_oe),
    .done    (hs_done),
    .timeout (hs_timeout),
    .nib_in  (hs_nib_in),
    .mem     (mem)
  );

  always_comb begin
    state_nx = state;
    hs_start = 1'b0;
    hs_nib   = '0;
    hs_oe    = 1'b0;
    case (state)
      IDLE: begin
        if (accept && !bcf_i) begin
          if (mem_write_i) begin
            state_nx = CMD;
            hs_start = 1'b1;
            hs_nib   = CMD_WR;
            hs_oe    = 1'b1;
          end else if (mem_read_i) begin
            state_nx = CMD;
            hs_start = 1'b1;
            hs_nib   = CMD_RD;
            hs_oe    = 1'b1;
          end
        end
      end
      DONE: state_nx = IDLE;
      default: begin
        if (hs_timeout) begin
          state_nx = IDLE;
        end else if (hs_done) begin
          case (state)
            CMD: begin
              state_nx = A_HI;
              hs_start = 1'b1;
              hs_nib   = addr_q[DATA_W-1 -: 4];
              hs_oe    = 1'b1;
            end
            A_HI: begin
              state_nx = A_LO;
              hs_start = 1'b1;
              hs_nib   = addr_q[3:0];
              hs_oe    = 1'b1;
            end
            A_LO: begin
              hs_start = 1'b1;
              if (op_rd_q) begin
                state_nx = R_HI;
              end else begin
                state_nx = D_HI;
                hs_nib   = wdata_q[DATA_W-1 -: 4];
                hs_oe    = 1'b1;
              end
            end
            D_HI: begin
              state_nx = D_LO;
              hs_start = 1'b1;
              hs_nib   = wdata_q[3:0];
              hs_oe    = 1'b1;
            end
            R_HI: begin
              state_nx = R_LO;
              hs_start = 1'b1;
            end
            default: state_nx = DONE;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc_o       <= '0;
      out_sel_o  <= 1'b0;
      rd_data_o  <= '0;
      rd_valid_o <= 1'b0;
      err_o      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      op_rd_q    <= 1'b0;
      rd_hi_q    <= '0;
    end else begin
      state      <= state_nx;
      rd_valid_o <= 1'b0;
      err_o      <= 1'b0;
      if (hs_start && state == IDLE) begin
        addr_q  <= r3_i;
        wdata_q <= data_i;
        op_rd_q <= !mem_write_i;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            if (bcf_i) begin
              pc_o <= pc_o + PC_W'(r3_i);
            end else if (!mem_write_i && !mem_read_i) begin
              pc_o <= pc_o + 1'b1;
              if (toggle_out_i) out_sel_o <= ~out_sel_o;
            end
          end
        end
        DONE: pc_o <= pc_o + 1'b1;
        default: begin
          if (hs_timeout) begin
            pc_o  <= pc_o + 1'b1;
            err_o <= 1'b1;
          end else if (hs_done) begin
            if (state == R_HI) rd_hi_q <= hs_nib_in;
            if (state == R_LO) begin
              rd_data_o  <= DATA_W'({rd_hi_q, hs_nib_in});
              rd_valid_o <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_strobe_exec_unit.sv
module tb_strobe_exec_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       instr_valid = 1'b0, bcf = 1'b0, mwr = 1'b0, mrd = 1'b0, tog = 1'b0;
  logic [7:0] r3 = 8'h00, wdata = 8'h00;
  logic [7:0] pc, rd_data, pin;
  logic       stall, rd_valid, err, out_sel;

  int tests = 0;
  int fails = 0;
  int mode  = 0;          // 0: ack follows req by 1 cycle, 1: ack stuck 0, 2: ack stuck 1
  int rv_cnt = 0, err_cnt = 0;
  logic       req_q;
  logic [3:0] read_q[$];
  logic [3:0] log_nib[$];
  logic       log_oe[$];

  // reference model state
  logic [7:0] m_pc = 8'h00, m_rd = 8'h00;
  logic       m_sel = 1'b0;

  always #5 clk = ~clk;

  strobe_exec_unit_if mbus();

  strobe_exec_unit #(.PC_W(8), .DATA_W(8), .TIMEOUT(15)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_valid_i (instr_valid),
    .bcf_i         (bcf),
    .mem_write_i   (mwr),
    .mem_read_i    (mrd),
    .toggle_out_i  (tog),
    .r3_i          (r3),
    .data_i        (wdata),
    .pc_o          (pc),
    .stall_o       (stall),
    .rd_data_o     (rd_data),
    .rd_valid_o    (rd_valid),
    .err_o         (err),
    .out_sel_o     (out_sel),
    .pin_o         (pin),
    .mem           (mbus)
  );

  // Memory responder: logs each nibble at req rise, serves read nibbles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mbus.ack_i <= 1'b0;
      mbus.bus_i <= 4'h0;
      req_q      <= 1'b0;
    end else begin
      req_q <= mbus.req_o;
      if (mbus.req_o && !req_q) begin
        log_nib.push_back(mbus.bus_o);
        log_oe.push_back(mbus.bus_oe_o);
        if (!mbus.bus_oe_o && read_q.size() > 0) mbus.bus_i <= read_q.pop_front();
      end
      case (mode)
        0:       mbus.ack_i <= mbus.req_o;
        1:       mbus.ack_i <= 1'b0;
        default: mbus.ack_i <= 1'b1;
      endcase
    end
  end

  always @(posedge clk) begin
    if (rd_valid === 1'b1) rv_cnt++;
    if (err === 1'b1) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic v, b, w, r, t, input logic [7:0] a, d);
    @(negedge clk);
    instr_valid = v; bcf = b; mwr = w; mrd = r; tog = t; r3 = a; wdata = d;
    @(negedge clk);
    instr_valid = 0; bcf = 0; mwr = 0; mrd = 0; tog = 0;
  endtask

  task automatic run_instr(input logic v, b, w, r, t, input logic [7:0] a, d,
                           input logic [3:0] n_hi, n_lo, input bit noise);
    bit         is_mem, is_rd;
    int         n, rv0;
    logic [3:0] exp_nib[5];
    logic       exp_oe[5];
    is_mem = v && !b && (w || r);
    is_rd  = is_mem && !w;
    log_nib.delete(); log_oe.delete(); read_q.delete();
    if (is_rd) begin read_q.push_back(n_hi); read_q.push_back(n_lo); end
    rv0 = rv_cnt;
    issue(v, b, w, r, t, a, d);
    if (!is_mem) begin
      if (v) begin
        if (b) m_pc = m_pc + a;
        else begin m_pc = m_pc + 8'd1; if (t) m_sel = ~m_sel; end
      end
      check("pc", pc, m_pc);
      check("out_sel", out_sel, m_sel);
      check("pin", pin, m_sel ? m_pc : a);
      check("stall_idle", stall, 0);
      return;
    end
    n = 0;
    while (stall === 1'b1 && n < 100) begin
      if (noise) begin instr_valid = 1; bcf = 1; tog = 1; r3 = 8'($urandom); end
      @(negedge clk);
      n++;
    end
    instr_valid = 0; bcf = 0; tog = 0; r3 = a;
    check("stall_cycles", n, 20);
    check("pc_held", pc, m_pc);
    check("rd_valid_done", rd_valid, is_rd);
    if (is_rd) m_rd = {n_hi, n_lo};
    check("rd_data", rd_data, m_rd);
    exp_nib[0] = w ? 4'b1000 : 4'b0100;
    exp_nib[1] = a[7:4]; exp_nib[2] = a[3:0];
    exp_nib[3] = d[7:4]; exp_nib[4] = d[3:0];
    for (int i = 0; i < 5; i++) exp_oe[i] = !(is_rd && i >= 3);
    check("nibble_count", log_nib.size(), 5);
    for (int i = 0; i < 5 && i < log_nib.size(); i++) begin
      check("bus_oe", log_oe[i], exp_oe[i]);
      if (exp_oe[i]) check("bus_nibble", log_nib[i], exp_nib[i]);
    end
    @(negedge clk);
    m_pc = m_pc + 8'd1;
    check("pc_after_op", pc, m_pc);
    check("stall_after_op", stall, 0);
    check("rd_valid_clear", rd_valid, 0);
    check("rd_valid_pulses", rv_cnt - rv0, is_rd);
    check("out_sel_op", out_sel, m_sel);
  endtask

  task automatic run_timeout(input int md, input logic w, input logic [7:0] a, d);
    int n, e0;
    mode = md;
    repeat (2) @(negedge clk);
    log_nib.delete(); log_oe.delete();
    e0 = err_cnt;
    issue(1, 0, w, !w, 0, a, d);
    n = 0;
    while (stall === 1'b1 && n < 100) begin @(negedge clk); n++; end
    check("to_stall_cycles", n, 15);
    check("to_err", err, 1);
    check("to_req", mbus.req_o, 0);
    check("to_oe", mbus.bus_oe_o, 0);
    m_pc = m_pc + 8'd1;
    check("to_pc", pc, m_pc);
    check("to_rd_data", rd_data, m_rd);
    check("to_rd_valid", rd_valid, 0);
    check("to_req_rises", log_nib.size(), (md == 1) ? 1 : 0);
    mode = 0;
    @(negedge clk);
    check("to_err_clear", err, 0);
    check("to_err_pulses", err_cnt - e0, 1);
  endtask

  initial begin
    logic       v, b, w, r, t;
    logic [7:0] a, d;
    int         n;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_pc", pc, 0);
    check("rst_stall", stall, 0);
    check("rst_req", mbus.req_o, 0);
    check("rst_oe", mbus.bus_oe_o, 0);
    check("rst_bus", mbus.bus_o, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_err", err, 0);
    check("rst_out_sel", out_sel, 0);
    rst_n = 1'b1;

    // branches, including wrap
    run_instr(1, 1, 0, 0, 0, 8'h10, 8'h00, 4'h0, 4'h0, 0);
    run_instr(1, 1, 0, 0, 0, 8'h05, 8'h00, 4'h0, 4'h0, 0);
    run_instr(1, 1, 0, 0, 0, 8'hE9, 8'h00, 4'h0, 4'h0, 0);
    run_instr(1, 1, 0, 0, 0, 8'h03, 8'h00, 4'h0, 4'h0, 0);

    // write and read transactions
    run_instr(1, 0, 1, 0, 0, 8'hA5, 8'h3C, 4'h0, 4'h0, 0);
    run_instr(1, 0, 0, 1, 0, 8'h12, 8'h00, 4'h7, 4'hE, 0);

    // timeouts: ack never rises, ack never falls
    run_timeout(1, 1, 8'h44, 8'h99);
    run_timeout(2, 0, 8'h21, 8'h00);

    // priority and ignored strobes
    run_instr(1, 1, 0, 0, 1, 8'h20, 8'h00, 4'h0, 4'h0, 0);
    run_instr(1, 1, 1, 1, 0, 8'h07, 8'h55, 4'h0, 4'h0, 0);
    run_instr(1, 0, 0, 0, 1, 8'h33, 8'h00, 4'h0, 4'h0, 0);
    run_instr(0, 1, 0, 0, 1, 8'h40, 8'h00, 4'h0, 4'h0, 0);
    run_instr(1, 0, 0, 0, 0, 8'h66, 8'h00, 4'h0, 4'h0, 0);
    run_instr(1, 0, 1, 1, 1, 8'hC3, 8'h5A, 4'h0, 4'h0, 1);
    run_instr(1, 0, 0, 1, 0, 8'h9E, 8'h00, 4'hB, 4'h2, 1);

    // randomized instruction mix
    for (int k = 0; k < 30; k++) begin
      v = ($urandom_range(0, 3) != 0);
      b = 1'($urandom); w = 1'($urandom); r = 1'($urandom); t = 1'($urandom);
      a = 8'($urandom); d = 8'($urandom);
      run_instr(v, b, w, r, t, a, d, 4'($urandom), 4'($urandom), 0);
    end

    // async reset during the A_LO phase
    log_nib.delete(); log_oe.delete();
    issue(1, 0, 1, 0, 0, 8'h5A, 8'h77);
    n = 0;
    while (log_nib.size() < 3 && n < 100) begin @(negedge clk); n++; end
    check("mid_alo_nibbles", log_nib.size(), 3);
    check("mid_alo_req", mbus.req_o, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_req", mbus.req_o, 0);
    check("arst_stall", stall, 0);
    check("arst_pc", pc, 0);
    check("arst_oe", mbus.bus_oe_o, 0);
    check("arst_bus", mbus.bus_o, 0);
    check("arst_out_sel", out_sel, 0);
    check("arst_rd_data", rd_data, 0);
    check("arst_err", err, 0);
    m_pc = 8'h00; m_sel = 1'b0; m_rd = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    run_instr(1, 0, 0, 0, 1, 8'h81, 8'h00, 4'h0, 4'h0, 0);
    run_instr(1, 0, 0, 1, 0, 8'h0F, 8'h00, 4'h5, 4'hA, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
